// File: rtl/singly_linked_list_walker.sv
// singly_linked_list_walker
// Walks a singly_linked_list instance from its head, issuing one Read_Addr
// request per node and emitting each node's (data, address) on a valid/ready
// stream with a last flag. The walk is bounded by the length captured at start,
// so a corrupted (cyclic) chain still terminates.

module singly_linked_list_walker #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8,
  parameter int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,

  // traversal control
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] list_head,
  input  logic [ADDR_WIDTH-1:0] list_length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] count,

  // command port towards the linked-list store
  output logic [2:0]            ll_op,
  output logic [ADDR_WIDTH-1:0] ll_addr,
  output logic [DATA_WIDTH-1:0] ll_data,
  output logic                  ll_op_start,
  input  logic                  ll_op_done,
  input  logic                  ll_fault,
  input  logic [DATA_WIDTH-1:0] ll_data_in,
  input  logic [ADDR_WIDTH-1:0] ll_next_in,

  // node stream
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  // Any next pointer at or above this value cannot name a real node, so the
  // chain is treated as ended there (compared unsigned).
  localparam logic [ADDR_WIDTH-1:0] MAX_NODE_A = ADDR_WIDTH'(MAX_NODE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_EMIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   length_r;   // length captured at start
  logic [ADDR_WIDTH-1:0]   next_r;     // next-node address of the node on the stream
  logic [ADDR_WIDTH-1:0]   count_inc_s;
  logic                    tail_hit_s;

  // The walker only ever reads; it never writes node data.
  assign ll_op   = 3'b000;
  assign ll_data = {DATA_WIDTH{1'b0}};

  // count can never exceed length_r (<= MAX_NODE), so this cannot wrap.
  assign count_inc_s = count + ADDR_WIDTH'(1);

  // The node being returned is the tail either because the captured length is
  // reached (its next field is then ignored: the list does not guarantee NULL
  // there) or because its next pointer does not name a valid node.
  assign tail_hit_s = (count_inc_s == length_r) | (ll_next_in >= MAX_NODE_A);

  // Traversal FSM: all control, stream and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      length_r    <= '0;
      next_r      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      count       <= '0;
      ll_addr     <= '0;
      ll_op_start <= 1'b0;
      m_data      <= '0;
      m_addr      <= '0;
      m_last      <= 1'b0;
      m_valid     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            length_r <= list_length;
            count    <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            if (list_length == '0) begin
              // Empty list: finish without touching the list at all.
              done    <= 1'b1;
              state_r <= S_FINISH;
            end else begin
              ll_addr     <= list_head;
              ll_op_start <= 1'b1;
              state_r     <= S_REQ;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        S_REQ: begin
          // op_start is held with a stable address until the list answers and
          // drops on that same edge, so the list never sees a repeated request.
          if (ll_op_done) begin
            ll_op_start <= 1'b0;
            if (ll_fault) begin
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= S_FINISH;
            end else begin
              m_data  <= ll_data_in;
              m_addr  <= ll_addr;
              next_r  <= ll_next_in;
              count   <= count_inc_s;
              m_last  <= tail_hit_s;
              m_valid <= 1'b1;
              state_r <= S_EMIT;
            end
          end else begin
            ll_op_start <= 1'b1;
          end
        end

        S_EMIT: begin
          // Beat is held stable until the consumer takes it.
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              // Ending before the captured length means the chain broke early.
              err     <= (count != length_r);
              done    <= 1'b1;
              state_r <= S_FINISH;
            end else begin
              ll_addr     <= next_r;
              ll_op_start <= 1'b1;
              state_r     <= S_REQ;
            end
          end else begin
            m_valid <= 1'b1;
          end
        end

        S_FINISH: begin
          // done is high for exactly this one cycle.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          // Unreachable encoding: return to a safe idle condition.
          state_r     <= S_IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          ll_op_start <= 1'b0;
          m_valid     <= 1'b0;
          m_last      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_singly_linked_list_walker.sv
// Directed testbench for singly_linked_list_walker with a small behavioural
// model of the linked-list store answering Read_Addr requests.

module tb_singly_linked_list_walker;

  localparam int DW = 8;
  localparam int MN = 8;
  localparam int AW = $clog2(MN + 1);
  localparam logic [AW-1:0] NULL_A = AW'(MN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] list_head;
  logic [AW-1:0] list_length;
  logic          busy, done, err;
  logic [AW-1:0] count;
  logic [2:0]    ll_op;
  logic [AW-1:0] ll_addr;
  logic [DW-1:0] ll_data;
  logic          ll_op_start;
  logic          ll_op_done;
  logic          ll_fault;
  logic [DW-1:0] ll_data_in;
  logic [AW-1:0] ll_next_in;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_last, m_valid, m_ready;

  int errors = 0;
  int checks = 0;

  singly_linked_list_walker #(.DATA_WIDTH(DW), .MAX_NODE(MN)) dut (
    .clk(clk), .rst(rst), .start(start), .list_head(list_head),
    .list_length(list_length), .busy(busy), .done(done), .err(err),
    .count(count), .ll_op(ll_op), .ll_addr(ll_addr), .ll_data(ll_data),
    .ll_op_start(ll_op_start), .ll_op_done(ll_op_done), .ll_fault(ll_fault),
    .ll_data_in(ll_data_in), .ll_next_in(ll_next_in), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // ---------------- linked-list store model ----------------
  logic [DW-1:0] mem_data  [16];
  logic [AW-1:0] mem_next  [16];
  logic          mem_valid [16];
  int            req_cnt   = 0;
  int            fault_cnt = 0;

  // Answers one request per op_start: op_done the cycle after op_start is seen.
  always @(posedge clk) begin
    if (rst) begin
      ll_op_done <= 1'b0;
      ll_fault   <= 1'b0;
      ll_data_in <= '0;
      ll_next_in <= '0;
    end else if (ll_op_done) begin
      ll_op_done <= 1'b0;
      ll_fault   <= 1'b0;
    end else if (ll_op_start) begin
      ll_op_done <= 1'b1;
      req_cnt    <= req_cnt + 1;
      if (ll_addr < AW'(MN) && mem_valid[ll_addr]) begin
        ll_fault   <= 1'b0;
        ll_data_in <= mem_data[ll_addr];
        ll_next_in <= mem_next[ll_addr];
      end else begin
        ll_fault   <= 1'b1;
        fault_cnt  <= fault_cnt + 1;
        ll_data_in <= '0;
        ll_next_in <= NULL_A;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_data[i]  = '0;
      mem_next[i]  = NULL_A;
      mem_valid[i] = 1'b0;
    end
  endtask

  task automatic set_node(input int idx, input logic [DW-1:0] d, input logic [AW-1:0] nxt);
    mem_data[idx]  = d;
    mem_next[idx]  = nxt;
    mem_valid[idx] = 1'b1;
  endtask

  // ---------------- traversal collector ----------------
  logic [DW-1:0] beat_data [8];
  logic [AW-1:0] beat_addr [8];
  logic          beat_last [8];
  int            beat_cyc  [8];
  int            nbeats, done_cyc, valid_seen, stall_opstart, stall_unstable;
  int            req_used, fault_used;
  logic          first_opstart, first_busy, post_busy, post_done;
  logic          done_err;
  logic [AW-1:0] done_count;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;

  // Pulses start (optionally held for one extra cycle), records every beat
  // with its cycle offset from the start cycle, and optionally stalls one beat.
  task automatic collect(input logic [AW-1:0] head, input logic [AW-1:0] len,
                         input int stall_idx, input int stall_n, input bit start_hold);
    int left;
    int req0;
    int flt0;
    nbeats = 0; done_cyc = -1; valid_seen = 0;
    stall_opstart = 0; stall_unstable = 0;
    req0 = req_cnt; flt0 = fault_cnt;
    left = stall_n;
    list_head = head; list_length = len; m_ready = 1'b1;
    start = 1'b1;
    tick();
    if (!start_hold) start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        first_opstart = ll_op_start;
        first_busy    = busy;
      end
      if (k == 2) start = 1'b0;
      if (done) begin
        done_cyc   = k;
        done_count = count;
        done_err   = err;
        break;
      end
      if (m_valid) begin
        valid_seen++;
        if (nbeats == stall_idx && left > 0) begin
          if (left == stall_n) begin
            hold_d = m_data;
            hold_a = m_addr;
          end else if (m_data !== hold_d || m_addr !== hold_a) begin
            stall_unstable++;
          end
          if (ll_op_start) stall_opstart++;
          m_ready = 1'b0;
          left--;
        end else begin
          m_ready = 1'b1;
          if (nbeats < 8) begin
            beat_data[nbeats] = m_data;
            beat_addr[nbeats] = m_addr;
            beat_last[nbeats] = m_last;
            beat_cyc[nbeats]  = k;
          end
          nbeats++;
        end
      end
      tick();
    end
    start = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL timeout: done=%0b after 60 cycles, required done pulse", done);
    end else begin
      tick();
      post_busy = busy;
      post_done = done;
    end
    req_used   = req_cnt - req0;
    fault_used = fault_cnt - flt0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    list_head = '0; list_length = '0;
    tick(); tick();
    checks++;
    if ({busy, done, err, ll_op_start, m_valid, m_last} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {busy, done, err, ll_op_start, m_valid, m_last});
    end
    checks++;
    if ({count, ll_addr, m_addr} !== {3{4'd0}} || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: count=%0d ll_addr=%0d m_addr=%0d m_data=%h required all 0", count, ll_addr, m_addr, m_data);
    end
    checks++;
    if (ll_op !== 3'b000 || ll_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_consts: ll_op=%b ll_data=%h required 000/00", ll_op, ll_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty();
    clear_mem();
    collect(4'd0, 4'd0, -1, 0, 1'b0);
    checks++;
    if (done_cyc !== 1) begin
      errors++;
      $display("FAIL empty_done_cycle: got %0d required 1", done_cyc);
    end
    checks++;
    if (first_opstart !== 1'b0 || req_used !== 0) begin
      errors++;
      $display("FAIL empty_no_request: op_start=%0b requests=%0d required 0/0", first_opstart, req_used);
    end
    checks++;
    if (done_err !== 1'b0 || done_count !== 4'd0 || nbeats !== 0) begin
      errors++;
      $display("FAIL empty_status: err=%0b count=%0d beats=%0d required 0/0/0", done_err, done_count, nbeats);
    end
  endtask

  task automatic check_three_beats(input string tag, input logic [DW-1:0] d0,
                                   input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    logic [DW-1:0] ed [3];
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    checks++;
    if (nbeats !== 3) begin
      errors++;
      $display("FAIL %s_beats: got %0d required 3", tag, nbeats);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beat_data[i] !== ed[i] || beat_addr[i] !== AW'(i) || beat_last[i] !== (i == 2)) begin
          errors++;
          $display("FAIL %s_beat%0d: got data=%h addr=%0d last=%0b required data=%h addr=%0d last=%0b",
                   tag, i, beat_data[i], beat_addr[i], beat_last[i], ed[i], i, (i == 2));
        end
      end
    end
    checks++;
    if (done_count !== 4'd3 || done_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: count=%0d err=%0b required 3/0", tag, done_count, done_err);
    end
  endtask

  task automatic load_push_back();
    clear_mem();
    set_node(0, 8'h11, 4'd1);
    set_node(1, 8'h22, 4'd2);
    set_node(2, 8'h33, NULL_A);
  endtask

  task automatic test_push_back();
    load_push_back();
    collect(4'd0, 4'd3, -1, 0, 1'b0);
    checks++;
    if (first_opstart !== 1'b1 || first_busy !== 1'b1) begin
      errors++;
      $display("FAIL pb_first_req: op_start=%0b busy=%0b at T+1 required 1/1", first_opstart, first_busy);
    end
    check_three_beats("pb", 8'h11, 8'h22, 8'h33);
    checks++;
    if (beat_cyc[0] !== 3 || beat_cyc[1] !== 6 || beat_cyc[2] !== 9 || done_cyc !== 10) begin
      errors++;
      $display("FAIL pb_timing: beats at %0d,%0d,%0d done %0d required 3,6,9 done 10",
               beat_cyc[0], beat_cyc[1], beat_cyc[2], done_cyc);
    end
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0 || req_used !== 3) begin
      errors++;
      $display("FAIL pb_after: busy=%0b done=%0b requests=%0d required 0/0/3", post_busy, post_done, req_used);
    end
  endtask

  task automatic test_backpressure();
    load_push_back();
    collect(4'd0, 4'd3, 1, 5, 1'b0);
    checks++;
    if (hold_d !== 8'h22 || hold_a !== 4'd1 || stall_unstable !== 0) begin
      errors++;
      $display("FAIL bp_stable: data=%h addr=%0d changes=%0d required 22/1/0", hold_d, hold_a, stall_unstable);
    end
    checks++;
    if (stall_opstart !== 0) begin
      errors++;
      $display("FAIL bp_no_req: op_start seen %0d stall cycles required 0", stall_opstart);
    end
    check_three_beats("bp", 8'h11, 8'h22, 8'h33);
    checks++;
    if (beat_cyc[1] !== 11 || beat_cyc[2] !== 14 || done_cyc !== 15) begin
      errors++;
      $display("FAIL bp_timing: beat1 %0d beat2 %0d done %0d required 11/14/15", beat_cyc[1], beat_cyc[2], done_cyc);
    end
  endtask

  task automatic test_non_contiguous();
    // After pushing A0..A2, deleting node 0 and pushing B0 to the front, node 0
    // is reused for B0. The tail's next field is left pointing at node 0 to
    // show it is ignored once the captured length is reached.
    clear_mem();
    set_node(0, 8'hB0, 4'd1);
    set_node(1, 8'hA1, 4'd2);
    set_node(2, 8'hA2, 4'd0);
    collect(4'd0, 4'd3, -1, 0, 1'b0);
    check_three_beats("nc", 8'hB0, 8'hA1, 8'hA2);
  endtask

  task automatic test_fault();
    clear_mem();
    load_push_back();
    collect(4'd5, 4'd1, -1, 0, 1'b0);
    checks++;
    if (fault_used !== 1 || done_cyc !== 3) begin
      errors++;
      $display("FAIL fault_seen: faults=%0d done at %0d required 1/3", fault_used, done_cyc);
    end
    checks++;
    if (done_err !== 1'b1 || done_count !== 4'd0 || valid_seen !== 0) begin
      errors++;
      $display("FAIL fault_status: err=%0b count=%0d valid cycles=%0d required 1/0/0", done_err, done_count, valid_seen);
    end
  endtask

  task automatic test_early_end();
    clear_mem();
    set_node(0, 8'h11, 4'd1);
    set_node(1, 8'h22, NULL_A);
    collect(4'd0, 4'd3, -1, 0, 1'b0);
    checks++;
    if (nbeats !== 2 || beat_last[1] !== 1'b1 || beat_data[1] !== 8'h22) begin
      errors++;
      $display("FAIL early_beats: beats=%0d last=%0b data=%h required 2/1/22", nbeats, beat_last[1], beat_data[1]);
    end
    checks++;
    if (done_err !== 1'b1 || done_count !== 4'd2) begin
      errors++;
      $display("FAIL early_status: err=%0b count=%0d required 1/2", done_err, done_count);
    end
  endtask

  task automatic test_reset_mid();
    load_push_back();
    list_head = 4'd0; list_length = 4'd3; m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) tick();
    checks++;
    if (ll_op_start !== 1'b1 || ll_addr !== 4'd2) begin
      errors++;
      $display("FAIL mid_req_node2: op_start=%0b addr=%0d required 1/2", ll_op_start, ll_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, err, ll_op_start, m_valid, m_last} !== 6'b000000 ||
        {count, ll_addr, m_addr} !== {3{4'd0}} || m_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: flags=%b count=%0d addr=%0d m_addr=%0d m_data=%h required all 0",
               {busy, done, err, ll_op_start, m_valid, m_last}, count, ll_addr, m_addr, m_data);
    end
    rst = 1'b0;
    collect(4'd0, 4'd3, -1, 0, 1'b0);
    check_three_beats("mid_restart", 8'h11, 8'h22, 8'h33);
  endtask

  task automatic test_back_to_back();
    load_push_back();
    // start held high into REQ must not restart the walk
    collect(4'd0, 4'd3, -1, 0, 1'b1);
    check_three_beats("b2b_first", 8'h11, 8'h22, 8'h33);
    checks++;
    if (done_cyc !== 10) begin
      errors++;
      $display("FAIL b2b_held_start: done at %0d required 10", done_cyc);
    end
    // new start on the first IDLE cycle, shorter length captured afresh
    collect(4'd0, 4'd2, -1, 0, 1'b0);
    checks++;
    if (nbeats !== 2 || beat_last[1] !== 1'b1 || beat_addr[1] !== 4'd1 ||
        done_count !== 4'd2 || done_err !== 1'b0 || done_cyc !== 7) begin
      errors++;
      $display("FAIL b2b_second: beats=%0d last=%0b addr=%0d count=%0d err=%0b done=%0d required 2/1/1/2/0/7",
               nbeats, beat_last[1], beat_addr[1], done_count, done_err, done_cyc);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_empty();
    test_push_back();
    test_backpressure();
    test_non_contiguous();
    test_fault();
    test_early_end();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
